mux_arbiter_4x1: RTL

MUX_ARBITER_4X1 -- requirements
Module: mux_arbiter_4x1

---
 rtl/mux_arbiter_4x1.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mux_arbiter_4x1.sv
`default_nettype none
// ============================================================================
// Module      : mux_arbiter_4x1
// Description : Four-input round-robin arbiter with a data mux. A grant is
//               held for up to MAX_BURST accepted beats, or until the
//               granted requester drops its request. At least one idle
//               cycle separates consecutive grants.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1         system clock, rising edge
//   rst_n      in   1         synchronous active-low reset
//   req        in   4         per-requester request/valid
//   in_data    in   4*DATA_W  requester data, requester i at [i*DATA_W +: DATA_W]
//   gnt        out  4         one-hot grant, zero when idle
//   in_ready   out  4         gnt[i] & out_ready
//   out_sel    out  2         index of the granted requester
//   out_data   out  DATA_W    data slice selected by out_sel
//   out_valid  out  1         grant held and req[out_sel] high
//   out_ready  in   1         downstream ready
//   busy       out  1         high while a grant is held
// ============================================================================
module mux_arbiter_4x1 #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   in_data,
    output logic [3:0]            gnt,
    output logic [3:0]            in_ready,
    output logic [1:0]            out_sel,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_grant = 1'b1;

    // Value of the beat counter when the final beat of a burst is accepted.
    localparam logic [3:0] c_last_beat = 4'(MAX_BURST - 1);

    logic [0:0]        state_q, state_d;
    logic [3:0]        gnt_q,   gnt_d;
    logic [1:0]        sel_q,   sel_d;
    logic [3:0]        beat_q,  beat_d;
    logic [1:0]        last_q,  last_d;

    logic [1:0]        w_win;
    logic              w_win_found;
    logic [1:0]        w_idx;
    logic              w_beat;
    logic [DATA_W-1:0] w_slice [4];

    // Split the flat data bus into per-requester words for the output mux.
    for (genvar i = 0; i < 4; i++) begin : g_split
        assign w_slice[i] = in_data[i*DATA_W +: DATA_W];
    end

    assign gnt       = gnt_q;
    assign out_sel   = sel_q;
    assign out_data  = w_slice[sel_q];
    assign busy      = (state_q == c_st_grant);
    assign out_valid = busy & req[sel_q];
    assign in_ready  = gnt_q & {4{out_ready}};
    assign w_beat    = out_valid & out_ready;

    // Round-robin search starting at last+1. Scanning from the farthest
    // candidate down to the nearest lets the nearest active one win.
    // k = 4 wraps back to last itself, which is lowest priority.
    always_comb begin
        w_win       = 2'd0;
        w_win_found = 1'b0;
        w_idx       = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            w_idx = last_q + 2'(k);
            if (req[w_idx]) begin
                w_win       = w_idx;
                w_win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        beat_d  = beat_q;
        last_d  = last_q;
        case (state_q)
            c_st_idle: begin
                if (w_win_found) begin
                    state_d = c_st_grant;
                    gnt_d   = 4'b0001 << w_win;
                    sel_d   = w_win;
                    beat_d  = 4'd0;
                end
            end
            default: begin
                // Release when the owner withdraws or the final beat lands.
                if (!req[sel_q] || (w_beat && (beat_q == c_last_beat))) begin
                    state_d = c_st_idle;
                    gnt_d   = 4'b0000;
                    beat_d  = 4'd0;
                    last_d  = sel_q;
                end else if (w_beat) begin
                    beat_d  = beat_q + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= c_st_idle;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            beat_q  <= 4'd0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
        end
    end

endmodule
`default_nettype wire
